// File: rtl/step_pkg.sv
// Shared types and default timing for the step pulse conditioner.
package step_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } step_state_e;

  localparam int unsigned TimerW       = 8;
  localparam int unsigned DefDirSetup  = 4;
  localparam int unsigned DefPulseHigh = 10;
  localparam int unsigned DefPulseLow  = 10;
  localparam int unsigned DefPosW      = 16;

endpackage

// File: rtl/step_width_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases; done while the count is zero.
module step_width_timer
  import step_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  output logic              done
);

  logic [TimerW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_conditioner.sv
// Turns raw DDA step edges into driver-safe step/dir pulses with setup, width and spacing
// guarantees, a 1-deep request buffer, limit-switch abort and a signed position counter.
module step_pulse_conditioner
  import step_pkg::*;
#(
  parameter int unsigned DIR_SETUP  = DefDirSetup,
  parameter int unsigned PULSE_HIGH = DefPulseHigh,
  parameter int unsigned PULSE_LOW  = DefPulseLow,
  parameter int unsigned POS_W      = DefPosW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    ls,
  input  logic                    clr_pos,
  output logic                    step_out,
  output logic                    dir_out,
  output logic signed [POS_W-1:0] pos,
  output logic                    busy,
  output logic                    overrun,
  output logic                    ls_hit
);

  step_state_e state_q, state_d;
  logic step_q, step_prev_q, dir_req_q;
  logic dir_q, dir_d;
  logic pend_q, pend_d, pend_dir_q, pend_dir_d;
  logic timer_load, timer_done;
  logic [TimerW-1:0] timer_val;
  logic req, serve, start_dir, drop, discard;
  logic step_out_d, busy_d, count;
  logic step_out_q, dir_out_q, busy_q, overrun_q, ls_hit_q;
  logic signed [POS_W-1:0] pos_q;

  // dir_in travels with the step sample so a same-cycle direction change binds to its edge.
  assign req = step_q & ~step_prev_q;

  step_width_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
      dir_req_q   <= 1'b0;
      dir_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_dir_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_in;
      step_prev_q <= step_q;
      dir_req_q   <= dir_in;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      pend_dir_q  <= pend_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    timer_load = 1'b0;
    timer_val  = '0;
    drop       = 1'b0;
    discard    = 1'b0;
    start_dir  = 1'b0;
    serve      = (state_q == StIdle) || ((state_q == StLow) && timer_done);
    if (ls) begin
      state_d = StIdle;
      pend_d  = 1'b0;
      discard = req | pend_q | (state_q == StSetup) | (state_q == StHigh);
    end else begin
      case (state_q)
        StSetup: if (timer_done) begin
          state_d    = StHigh;
          timer_load = 1'b1;
          timer_val  = TimerW'(PULSE_HIGH - 1);
        end
        StHigh: if (timer_done) begin
          state_d    = StLow;
          timer_load = 1'b1;
          timer_val  = TimerW'(PULSE_LOW - 1);
        end
        default: ;
      endcase
      if (serve) begin
        if (pend_q || req) begin
          start_dir  = pend_q ? pend_dir_q : dir_req_q;
          pend_d     = 1'b0;
          timer_load = 1'b1;
          if (start_dir == dir_q) begin
            state_d   = StHigh;
            timer_val = TimerW'(PULSE_HIGH - 1);
          end else begin
            state_d   = StSetup;
            dir_d     = start_dir;
            timer_val = TimerW'(DIR_SETUP - 1);
          end
        end else begin
          state_d = StIdle;
        end
        drop = pend_q & req;
      end else if (req) begin
        if (pend_q) begin
          drop = 1'b1;
        end else begin
          pend_d     = 1'b1;
          pend_dir_d = dir_req_q;
        end
      end
    end
  end

  always_comb begin
    step_out_d = (state_q == StHigh) && !ls;
    busy_d     = (state_q != StIdle) || pend_q;
    count      = (state_q == StHigh) && timer_done && !ls;
  end

  // Outputs are registered so the driver never sees combinational glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_out_q <= 1'b0;
      dir_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      pos_q      <= '0;
      overrun_q  <= 1'b0;
      ls_hit_q   <= 1'b0;
    end else begin
      step_out_q <= step_out_d;
      dir_out_q  <= dir_q;
      busy_q     <= busy_d;
      if (clr_pos) begin
        pos_q     <= '0;
        overrun_q <= 1'b0;
        ls_hit_q  <= 1'b0;
      end else begin
        if (count) pos_q <= dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
        if (drop) overrun_q <= 1'b1;
        if (discard) ls_hit_q <= 1'b1;
      end
    end
  end

  assign step_out = step_out_q;
  assign dir_out  = dir_out_q;
  assign busy     = busy_q;
  assign pos      = pos_q;
  assign overrun  = overrun_q;
  assign ls_hit   = ls_hit_q;

endmodule

// File: doc/step_pulse_conditioner.md
STEP_PULSE_CONDITIONER -- requirements
Module: step_pulse_conditioner

Interface
REQ-001 SHALL have parameter DIR_SETUP, default 4: step_out low cycles after a dir_out change, range 1..255.
REQ-002 SHALL have parameter PULSE_HIGH, default 10: step_out high width in cycles, range 1..255.
REQ-003 SHALL have parameter PULSE_LOW, default 10: minimum step_out low width after each pulse in cycles, range 1..255.
REQ-004 SHALL have parameter POS_W, default 16: position counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 step_in  in  1  raw step pulse from the DDA pulse generator; rising edge = one step request.
REQ-009 dir_in  in  1  direction from the generator; 0 = positive, 1 = negative.
REQ-010 ls  in  1  limit switch, active high.
REQ-011 clr_pos  in  1  single-cycle clear of pos and sticky flags.
REQ-012 step_out  out  1  conditioned step to the motor driver.
REQ-013 dir_out  out  1  conditioned direction to the motor driver.
REQ-014 pos  out  POS_W  signed two's-complement absolute position.
REQ-015 busy  out  1  high when the FSM is not IDLE or the pending slot is full.
REQ-016 overrun  out  1  sticky flag: a step request was dropped.
REQ-017 ls_hit  out  1  sticky flag: a step was discarded or aborted by ls.

Function
REQ-018 SHALL register step_in once; a step request is step_in=1 with the previous sample 0.
REQ-019 SHALL use FSM states IDLE, SETUP, HIGH, LOW with an 8-bit down-counter timer.
REQ-020 IDLE, request, requested dir == dir_out: SHALL go to HIGH; step_out rises 2 cycles after step_in is first sampled high.
REQ-021 IDLE, request, requested dir != dir_out: SHALL load dir_out and go to SETUP; step_out rises DIR_SETUP cycles later than in REQ-020.
REQ-022 SHALL hold step_out=1 for exactly PULSE_HIGH cycles in HIGH, then hold 0 for PULSE_LOW cycles in LOW.
REQ-023 On the last HIGH cycle, pos SHALL increment (dir_out=0) or decrement (dir_out=1) by 1, wrapping modulo 2^POS_W.
REQ-024 A request outside IDLE SHALL go to a 1-deep pending slot with its dir_in; on leaving LOW the FSM SHALL serve pending as in REQ-020/021, else return to IDLE.
REQ-025 A request with the pending slot full SHALL be dropped and SHALL set overrun.
REQ-026 ls=1 SHALL: clear pending; discard requests; abort SETUP/HIGH/LOW to IDLE next cycle; force step_out=0 next cycle; set ls_hit if a request or pulse was discarded.
REQ-027 An aborted HIGH pulse SHALL NOT change pos.
REQ-028 clr_pos SHALL set pos=0 and clear overrun and ls_hit next cycle; clr_pos wins over a simultaneous count or flag set.
REQ-029 Request and dir change in the same cycle SHALL use the dir_in sampled with the request edge.

Reset
REQ-030 rst SHALL force: IDLE, pending empty, step_out=0, dir_out=0, pos=0, busy=0, overrun=0, ls_hit=0, step_in sample=0.
REQ-031 rst SHALL override all inputs; a pulse cut by mid-operation reset SHALL NOT count.

Structure
REQ-032 Package step_pkg SHALL hold the FSM state typedef, default timing constants and POS_W default.
REQ-033 SHALL contain one sub-module, step_width_timer: loadable 8-bit down-counter with a done output, shared by SETUP/HIGH/LOW.

Verification (defaults)
REQ-034 Reset; dir_in=0, step_in rises at cycle 0 -> step_out high cycles 2..11; pos=1 after cycle 11; busy low from cycle 22.
REQ-035 dir_in=1, one step -> dir_out=1 at cycle 2; step_out high cycles 6..15; pos 1->0.
REQ-036 Three step edges 3 cycles apart -> two pulses output 10 low cycles apart; overrun=1; pos=+2.
REQ-037 ls=1 at the 5th HIGH cycle -> step_out=0 next cycle; pos unchanged; ls_hit=1; pending cleared.
REQ-038 pos=32767, one forward step -> pos=-32768; clr_pos in the same cycle as a count -> pos=0, flags 0.
REQ-039 rst during LOW with pending full -> all outputs at reset values next cycle; no pending pulse emitted.
